// File: rtl/ctrl_pkg.sv
// Shared encodings for the multi-cycle controller: states, ALU ops,
// R-type func codes and error codes.
package ctrl_pkg;

    typedef enum logic [2:0] {
        S_FETCH    = 3'd0,
        S_WAIT_MEM = 3'd1,
        S_DECODE   = 3'd2,
        S_EXEC     = 3'd3,
        S_WB       = 3'd4,
        S_HALT     = 3'd5
    } state_t;

    localparam logic [2:0] ALU_AND  = 3'b000;
    localparam logic [2:0] ALU_OR   = 3'b001;
    localparam logic [2:0] ALU_XOR  = 3'b010;
    localparam logic [2:0] ALU_NOR  = 3'b011;
    localparam logic [2:0] ALU_ADD  = 3'b100;
    localparam logic [2:0] ALU_SUB  = 3'b101;
    localparam logic [2:0] ALU_SLT  = 3'b110;
    localparam logic [2:0] ALU_SLLV = 3'b111;

    localparam logic [5:0] OP_RTYPE  = 6'b000000;
    localparam logic [5:0] FN_AND    = 6'b100100;
    localparam logic [5:0] FN_OR     = 6'b100101;
    localparam logic [5:0] FN_XOR    = 6'b100110;
    localparam logic [5:0] FN_NOR    = 6'b100111;
    localparam logic [5:0] FN_ADD    = 6'b100000;
    localparam logic [5:0] FN_SUB    = 6'b100010;
    localparam logic [5:0] FN_SLT    = 6'b101010;
    localparam logic [5:0] FN_SLLV   = 6'b000100;

    localparam logic [1:0] ERR_NONE     = 2'b00;
    localparam logic [1:0] ERR_ILLEGAL  = 2'b01;
    localparam logic [1:0] ERR_TIMEOUT  = 2'b10;
    localparam logic [1:0] ERR_OVERFLOW = 2'b11;

endpackage

// File: rtl/ctrl_decode.sv
// Combinational instruction decode: op/func to ALU operation plus
// an illegal-instruction flag.
module ctrl_decode
    import ctrl_pkg::*;
(
    input  logic [5:0] op,
    input  logic [5:0] func,
    output logic [2:0] alu_op,
    output logic       illegal
);

    always_comb begin
        alu_op  = ALU_AND;
        illegal = 1'b0;
        unique case (func)
            FN_AND:  alu_op = ALU_AND;
            FN_OR:   alu_op = ALU_OR;
            FN_XOR:  alu_op = ALU_XOR;
            FN_NOR:  alu_op = ALU_NOR;
            FN_ADD:  alu_op = ALU_ADD;
            FN_SUB:  alu_op = ALU_SUB;
            FN_SLT:  alu_op = ALU_SLT;
            FN_SLLV: alu_op = ALU_SLLV;
            default: illegal = 1'b1;
        endcase
        if (op != OP_RTYPE) begin
            illegal = 1'b1;
        end
    end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multi-cycle CPU sequencer: FETCH, WAIT_MEM, DECODE, EXEC, WB, HALT.
// Optional single-step gating of FETCH with macro CTRL_STEP_EN.
module multicycle_ctrl
    import ctrl_pkg::*;
#(
    parameter int CNT_W       = 32,
    parameter int MEM_TIMEOUT = 15
) (
    input  logic             CLK,
    input  logic             RST,
`ifdef CTRL_STEP_EN
    input  logic             STEP,
`endif
    output logic             IMEM_REQ,
    input  logic             IMEM_RDY,
    input  logic [31:0]      INST,
    output logic [31:0]      IR,
    output logic             PC_WE,
    output logic             REG_WE,
    output logic [2:0]       ALU_OP,
    input  logic             ALU_OF,
    output logic             HALTED,
    output logic [1:0]       ERR,
    output logic [CNT_W-1:0] RETIRED,
    output logic [2:0]       STATE
);

    localparam logic [7:0] TMO_LAST = 8'(MEM_TIMEOUT - 1);

    state_t     state;
    state_t     state_d;
    logic [7:0] tcnt;
    logic [7:0] tcnt_d;
    logic [1:0] err_d;
    logic       ir_ld;
    logic       op_ld;
    logic       retire;
    logic       go;
    logic       is_arith;
    logic [2:0] dec_op;
    logic       dec_ill;

`ifdef CTRL_STEP_EN
    assign go = STEP;
`else
    assign go = 1'b1;
`endif

    ctrl_decode u_decode (
        .op      (IR[5:0]),
        .func    (IR[31:26]),
        .alu_op  (dec_op),
        .illegal (dec_ill)
    );

    assign is_arith = (ALU_OP == ALU_ADD) || (ALU_OP == ALU_SUB);

    always_comb begin
        state_d = state;
        err_d   = ERR;
        tcnt_d  = '0;
        ir_ld   = 1'b0;
        op_ld   = 1'b0;
        retire  = 1'b0;
        unique case (state)
            S_FETCH: begin
                if (go) state_d = S_WAIT_MEM;
            end
            S_WAIT_MEM: begin
                // Data arriving on the timeout cycle still wins
                if (IMEM_RDY) begin
                    ir_ld   = 1'b1;
                    state_d = S_DECODE;
                end else if (tcnt == TMO_LAST) begin
                    err_d   = ERR_TIMEOUT;
                    state_d = S_HALT;
                end else begin
                    tcnt_d = tcnt + 8'd1;
                end
            end
            S_DECODE: begin
                if (dec_ill) begin
                    err_d   = ERR_ILLEGAL;
                    state_d = S_HALT;
                end else begin
                    op_ld   = 1'b1;
                    state_d = S_EXEC;
                end
            end
            S_EXEC: begin
                if (is_arith && ALU_OF) begin
                    err_d   = ERR_OVERFLOW;
                    state_d = S_HALT;
                end else begin
                    state_d = S_WB;
                end
            end
            S_WB: begin
                retire  = 1'b1;
                state_d = S_FETCH;
            end
            S_HALT: begin
                state_d = S_HALT;
            end
            default: state_d = S_FETCH;
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state    <= S_FETCH;
            tcnt     <= '0;
            IR       <= '0;
            IMEM_REQ <= 1'b0;
            ALU_OP   <= ALU_AND;
            ERR      <= ERR_NONE;
            RETIRED  <= '0;
        end else begin
            state    <= state_d;
            tcnt     <= tcnt_d;
            IMEM_REQ <= (state_d == S_WAIT_MEM);
            ERR      <= err_d;
            if (ir_ld)  IR      <= INST;
            if (op_ld)  ALU_OP  <= dec_op;
            if (retire) RETIRED <= RETIRED + CNT_W'(1);
        end
    end

    // Pulses derive from state so an async reset cancels them at once
    assign PC_WE  = (state == S_WB);
    assign REG_WE = (state == S_WB);
    assign HALTED = (state == S_HALT);
    assign STATE  = state;

endmodule
